rhythm_sequencer: RTL and testbench

Central game controller for the note-lane rhythm game. It reads a song pattern from an external ROM row by row, advances all note lanes on a programmable tick, and judges player taps against the hit position of each lane. It also maintains the saturating score and runs the IDLE/PLAY/PAUSE/DONE game state machine. It sits between the board switches/keys and the LED/seven-segment display logic, and replaces ad-hoc per-lane shifting and tap handling.

---
 rtl/rhythm_sequencer_pkg.sv | 14 +
 rtl/rhythm_sequencer_if.sv | 11 +
 rtl/rhythm_sequencer_tick_gen.sv | 26 ++
 rtl/rhythm_sequencer.sv | 114 +++++++++++
 tb/tb_rhythm_sequencer.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/rhythm_sequencer_pkg.sv
// rtl/rhythm_sequencer_pkg.sv - game_pkg: game state encoding and scoring constants
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } game_state_t;

  localparam int HIT_PTS  = 1;
  localparam int MISS_PTS = 2;

endpackage

// File: rtl/rhythm_sequencer_if.sv
// rtl/rhythm_sequencer_if.sv - song pattern ROM bus between sequencer (master) and ROM (slave)
interface rhythm_sequencer_if #(
  parameter int LANES  = 4,
  parameter int ADDR_W = 7
);
  logic [ADDR_W-1:0] rom_addr;
  logic [LANES-1:0]  rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/rhythm_sequencer_tick_gen.sv
// rtl/rhythm_sequencer_tick_gen.sv - tick_gen: clock divider with freeze and sync clear, 1-cycle tick
module tick_gen #(
  parameter int DIV = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  // Tick fires while the counter sits on its last value, so the consumer acts on the wrap edge.
  assign tick = enable && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (tick) cnt <= '0;
      else      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/rhythm_sequencer.sv
// rtl/rhythm_sequencer.sv - note-lane game controller; miss penalty enabled by GAME_MISS_PENALTY_EN
module rhythm_sequencer
  import game_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int WINDOW   = 10,
  parameter int SONG_LEN = 100,
  parameter int TICK_DIV = 10_000_000,
  parameter int SCORE_W  = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    run,
  input  logic [LANES-1:0]        tap,
  rhythm_sequencer_if.master      rom,
  output logic [LANES*WINDOW-1:0] lane_view,
  output logic [SCORE_W-1:0]      score,
  output logic [1:0]              state,
  output logic                    done
);
  localparam int ADDR_W = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
  localparam int DW     = SCORE_W + 3;

  game_state_t                  st;
  logic                         start_d;
  logic [LANES-1:0]             tap_d;
  logic [LANES-1:0]             tap_rise;
  logic [LANES-1:0][WINDOW-1:0] lanes;
  logic                         all_loaded;
  logic                         tick;
  logic                         begin_game;
  logic signed [DW-1:0]         delta;
  logic signed [DW-1:0]         sum;
  logic [SCORE_W-1:0]           score_next;

  assign lane_view  = lanes;
  assign state      = st;
  assign tap_rise   = tap & ~tap_d;
  assign begin_game = start && !start_d && (st == IDLE || st == DONE);

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clear  (begin_game),
    .enable (st == PLAY),
    .tick   (tick)
  );

  // All lanes judged together; one net delta is applied and then saturated.
  always_comb begin
    delta = '0;
    for (int i = 0; i < LANES; i++) begin
      if (tap_rise[i]) begin
        if (lanes[i][0]) delta = delta + DW'(HIT_PTS);
`ifdef GAME_MISS_PENALTY_EN
        else             delta = delta - DW'(MISS_PTS);
`endif
      end
    end
    sum = $signed({3'b000, score}) + delta;
    if (sum < 0)                                        score_next = '0;
    else if (sum > $signed({3'b000, {SCORE_W{1'b1}}})) score_next = '1;
    else                                                score_next = sum[SCORE_W-1:0];
  end

  always_ff @(posedge clk) begin
    start_d <= start;
    tap_d   <= tap;
    if (reset) begin
      st           <= IDLE;
      lanes        <= '0;
      score        <= '0;
      rom.rom_addr <= '0;
      all_loaded   <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (st)
        IDLE, DONE: begin
          if (begin_game) begin
            st           <= PLAY;
            done         <= 1'b0;
            lanes        <= '0;
            score        <= '0;
            rom.rom_addr <= '0;
            all_loaded   <= 1'b0;
          end
        end
        PLAY: begin
          score <= score_next;
          // A tick shift discards bit 0 anyway, so it takes precedence over the hit clear.
          for (int i = 0; i < LANES; i++) begin
            if (tick)             lanes[i] <= {all_loaded ? 1'b0 : rom.rom_data[i], lanes[i][WINDOW-1:1]};
            else if (tap_rise[i]) lanes[i][0] <= 1'b0;
          end
          if (tick && !all_loaded) begin
            if (rom.rom_addr == ADDR_W'(SONG_LEN - 1)) all_loaded   <= 1'b1;
            else                                       rom.rom_addr <= rom.rom_addr + 1'b1;
          end
          if (!run) begin
            st <= PAUSE;
          end else if (all_loaded && lanes == '0) begin
            st   <= DONE;
            done <= 1'b1;
          end
        end
        PAUSE: begin
          if (run) st <= PLAY;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rhythm_sequencer.sv
// tb/tb_rhythm_sequencer.sv - randomized self-checking bench with a cycle-level game model
module tb_rhythm_sequencer;
  localparam int LANES    = 2;
  localparam int WINDOW   = 4;
  localparam int SONG_LEN = 4;
  localparam int TICK_DIV = 4;
  localparam int SCORE_W  = 5;
  localparam int SAT_W    = 2;
  localparam int ADDR_W   = 2;
`ifdef GAME_MISS_PENALTY_EN
  localparam int MISS = 2;
`else
  localparam int MISS = 0;
`endif

  logic                    clk = 1'b0;
  logic                    reset, start, run;
  logic [LANES-1:0]        tap;
  logic [LANES*WINDOW-1:0] lane_view, lane_view2;
  logic [SCORE_W-1:0]      score;
  logic [SAT_W-1:0]        score2;
  logic [1:0]              state, state2;
  logic                    done, done2;
  logic [LANES-1:0]        rom [SONG_LEN];

  int total = 0;
  int bad   = 0;

  int m_state, m_cnt, m_rows, m_score, m_score2, m_done, m_start_d;
  int m_tap_d [LANES];
  int m_lane  [LANES][WINDOW];
  int pause_left;

  rhythm_sequencer_if #(.LANES(LANES), .ADDR_W(ADDR_W)) rom_bus  ();
  rhythm_sequencer_if #(.LANES(LANES), .ADDR_W(ADDR_W)) rom_bus2 ();

  rhythm_sequencer #(.LANES(LANES), .WINDOW(WINDOW), .SONG_LEN(SONG_LEN),
                     .TICK_DIV(TICK_DIV), .SCORE_W(SCORE_W)) dut (
    .clk(clk), .reset(reset), .start(start), .run(run), .tap(tap), .rom(rom_bus.master),
    .lane_view(lane_view), .score(score), .state(state), .done(done)
  );

  rhythm_sequencer #(.LANES(LANES), .WINDOW(WINDOW), .SONG_LEN(SONG_LEN),
                     .TICK_DIV(TICK_DIV), .SCORE_W(SAT_W)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .run(run), .tap(tap), .rom(rom_bus2.master),
    .lane_view(lane_view2), .score(score2), .state(state2), .done(done2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_bus.rom_data  <= rom[rom_bus.rom_addr];
    rom_bus2.rom_data <= rom[rom_bus2.rom_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  function automatic logic [LANES*WINDOW-1:0] exp_view();
    logic [LANES*WINDOW-1:0] v;
    v = '0;
    for (int l = 0; l < LANES; l++)
      for (int p = 0; p < WINDOW; p++)
        v[l*WINDOW + p] = (m_lane[l][p] != 0);
    return v;
  endfunction

  task automatic clear_lanes();
    for (int l = 0; l < LANES; l++)
      for (int p = 0; p < WINDOW; p++)
        m_lane[l][p] = 0;
  endtask

  // One clock of game rules, evaluated on the inputs that the coming edge samples.
  task automatic model_step();
    int net, empty, rows_before;
    if (reset) begin
      m_state = 0; m_cnt = 0; m_rows = 0; m_score = 0; m_score2 = 0; m_done = 0;
      clear_lanes();
    end else begin
      case (m_state)
        0, 3: if (start && m_start_d == 0) begin
          m_state = 1; m_done = 0; m_cnt = 0; m_rows = 0; m_score = 0; m_score2 = 0;
          clear_lanes();
        end
        1: begin
          net = 0; empty = 1; rows_before = m_rows;
          for (int l = 0; l < LANES; l++) begin
            for (int p = 0; p < WINDOW; p++) if (m_lane[l][p] != 0) empty = 0;
            if (tap[l] && m_tap_d[l] == 0) begin
              if (m_lane[l][0] != 0) begin net += 1; m_lane[l][0] = 0; end
              else net -= MISS;
            end
          end
          m_score  = clamp(m_score + net, (1 << SCORE_W) - 1);
          m_score2 = clamp(m_score2 + net, (1 << SAT_W) - 1);
          if (m_cnt == TICK_DIV - 1) begin
            for (int l = 0; l < LANES; l++) begin
              for (int p = 0; p < WINDOW - 1; p++) m_lane[l][p] = m_lane[l][p+1];
              m_lane[l][WINDOW-1] = (m_rows < SONG_LEN) ? int'(rom[m_rows][l]) : 0;
            end
            if (m_rows < SONG_LEN) m_rows++;
            m_cnt = 0;
          end else begin
            m_cnt++;
          end
          if (!run) m_state = 2;
          else if (rows_before == SONG_LEN && empty != 0) begin m_state = 3; m_done = 1; end
        end
        2: if (run) m_state = 1;
        default: m_state = 0;
      endcase
    end
    m_start_d = start;
    for (int l = 0; l < LANES; l++) m_tap_d[l] = tap[l];
  endtask

  task automatic step();
    int exp_addr;
    model_step();
    @(posedge clk);
    #1;
    exp_addr = (m_rows > SONG_LEN - 1) ? SONG_LEN - 1 : m_rows;
    chk("state",     state,            m_state);
    chk("score",     score,            m_score);
    chk("lane_view", lane_view,        exp_view());
    chk("rom_addr",  rom_bus.rom_addr, exp_addr);
    chk("done",      done,             m_done);
    chk("sat_score", score2,           m_score2);
    chk("sat_state", state2,           m_state);
  endtask

  initial begin
    m_state = 0; m_cnt = 0; m_rows = 0; m_score = 0; m_score2 = 0; m_done = 0; m_start_d = 0;
    for (int l = 0; l < LANES; l++) m_tap_d[l] = 0;
    clear_lanes();
    rom[0] = 2'b01; rom[1] = 2'b10; rom[2] = 2'b11; rom[3] = 2'b00;
    reset = 1'b1; start = 1'b1; run = 1'b1; tap = '0; pause_left = 0;

    repeat (3) step();
    reset = 1'b0;
    repeat (3) step();
    chk("no_autostart", state, 0);

    start = 1'b0; step();
    start = 1'b1; step();
    repeat (45) step();
    chk("song_done_state", state, 3);
    chk("song_done_flag",  done, 1);

    start = 1'b0; step();
    start = 1'b1; step();
    for (int k = 0; k < 40 && m_lane[0][0] == 0; k++) step();
    tap = 2'b01;
    repeat (6) step();
    chk("held_tap_once", score, 1);
    tap = '0; step();

    run = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tap = LANES'($urandom);
      step();
    end
    run = 1'b1; tap = '0;
    repeat (6) step();
    run = 1'b0; repeat (5) step();
    reset = 1'b1; step();
    chk("reset_in_pause_state", state, 0);
    chk("reset_in_pause_lanes", lane_view, 0);
    reset = 1'b0; run = 1'b1; step();

    for (int n = 0; n < 4000; n++) begin
      if (($urandom % 10) == 0) begin
        if (!start && (m_state == 0 || m_state == 3))
          for (int r = 0; r < SONG_LEN; r++) rom[r] = LANES'($urandom);
        start = !start;
      end
      if (pause_left > 0) begin
        run = 1'b0; pause_left--;
      end else begin
        run = 1'b1;
        if (($urandom % 60) == 0) pause_left = $urandom_range(1, 25);
      end
      reset = (($urandom % 500) == 0);
      for (int l = 0; l < LANES; l++) begin
        if (tap[l])                 tap[l] = ($urandom_range(0, 1) == 0);
        else if (m_lane[l][0] != 0) tap[l] = ($urandom_range(0, 2) == 0);
        else                        tap[l] = ($urandom_range(0, 19) == 0);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
